// File: rtl/io_pkg.sv
// Shared types and constants for the IO responder: FSM states, byte width,
// and a saturating counter helper.
package io_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE,
        HOLD
    } io_state_e;

    function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
        return (v == {BYTE_W{1'b1}}) ? v : v + BYTE_W'(1);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers. Exposes the head and the entry behind it
// so a consumer can register the post-pop head in the same cycle.
module byte_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     push_i,
    input  logic [BYTE_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [BYTE_W-1:0]        head_o,
    output logic [BYTE_W-1:0]        next_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     rd_nxt_idx;
    logic              do_push;
    logic              do_pop;

    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign rd_nxt_idx = rd_idx + AW'(1);

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_idx];
    assign next_o  = mem_q[rd_nxt_idx];

    // A pop frees the slot the push lands in, so full+pop still accepts.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/io_responder.sv
// Processor IO handshake to UART byte-stream bridge with RX/TX FIFOs.
// Define IO_OVERRUN_EN to add the sticky rx_overrun flag and rx_drop_cnt.
module io_responder
    import io_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              io_read_req,
    input  logic              io_write_req,
    input  logic [BYTE_W-1:0] io_wdata,
    output logic              io_ready,
    output logic              io_done,
    output logic [BYTE_W-1:0] io_rdata,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready
`ifdef IO_OVERRUN_EN
    ,
    output logic              rx_overrun,
    output logic [BYTE_W-1:0] rx_drop_cnt
`endif
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    io_state_e         state_q;
    logic              io_ready_q;
    logic              io_done_q;
    logic [BYTE_W-1:0] io_rdata_q;
    logic [BYTE_W-1:0] wbyte_q;
    logic              tx_valid_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic              tx_valid_d;

    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [BYTE_W-1:0] rx_head, rx_next, tx_head, tx_next;
    logic [RX_AW:0]    rx_level;
    logic [TX_AW:0]    tx_level;
    logic              rx_pop, tx_push, tx_pop;

    assign rx_pop  = (state_q == RD_WAIT) && !rx_empty;
    assign tx_push = (state_q == WR_WAIT) && !tx_full;
    assign tx_pop  = tx_valid_q && tx_ready;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (CLK),
        .srst_i  (RST),
        .push_i  (rx_valid),
        .data_i  (rx_data),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head),
        .next_o  (rx_next),
        .level_o (rx_level)
    );

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (CLK),
        .srst_i  (RST),
        .push_i  (tx_push),
        .data_i  (wbyte_q),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_head),
        .next_o  (tx_next),
        .level_o (tx_level)
    );

    logic unused_rx;
    assign unused_rx = ^{rx_next, rx_level, rx_full};

    // io_ready_q tracks "next state is IDLE"; only IDLE and HOLD can get there.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            io_ready_q <= 1'b0;
            io_done_q  <= 1'b0;
            io_rdata_q <= '0;
            wbyte_q    <= '0;
        end else begin
            io_done_q  <= 1'b0;
            io_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (io_read_req) begin
                        state_q <= RD_WAIT;
                    end else if (io_write_req) begin
                        wbyte_q <= io_wdata;
                        state_q <= WR_WAIT;
                    end else begin
                        io_ready_q <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (rx_pop) begin
                        io_rdata_q <= rx_head;
                        io_done_q  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                WR_WAIT: begin
                    if (tx_push) begin
                        io_done_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: state_q <= HOLD;
                HOLD: begin
                    if (!io_read_req && !io_write_req) begin
                        io_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs show the head after this cycle's pop but before this cycle's push,
    // so a fresh byte becomes visible one cycle after it lands in the FIFO.
    assign tx_valid_d = tx_pop ? (tx_level > (TX_AW+1)'(1)) : !tx_empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_valid_q <= tx_valid_d;
            if (tx_valid_d) tx_data_q <= tx_pop ? tx_next : tx_head;
        end
    end

`ifdef IO_OVERRUN_EN
    logic              rx_overrun_q;
    logic [BYTE_W-1:0] rx_drop_cnt_q;
    logic              rx_drop;

    assign rx_drop = rx_valid && rx_full && !rx_pop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_overrun_q  <= 1'b0;
            rx_drop_cnt_q <= '0;
        end else if (rx_drop) begin
            rx_overrun_q  <= 1'b1;
            rx_drop_cnt_q <= sat_inc(rx_drop_cnt_q);
        end
    end

    assign rx_overrun  = rx_overrun_q;
    assign rx_drop_cnt = rx_drop_cnt_q;
`endif

    assign io_ready = io_ready_q;
    assign io_done  = io_done_q;
    assign io_rdata = io_rdata_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_io_responder.sv
// Randomized bench for io_responder against a queue-based reference model.
module tb_io_responder;

    localparam int RXD = 16;
    localparam int TXD = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       io_read_req = 1'b0;
    logic       io_write_req = 1'b0;
    logic [7:0] io_wdata = 8'h00;
    logic       io_ready, io_done;
    logic [7:0] io_rdata;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
`ifdef IO_OVERRUN_EN
    logic       rx_overrun;
    logic [7:0] rx_drop_cnt;
`endif

    always #5 CLK = ~CLK;

    io_responder #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .io_read_req  (io_read_req),
        .io_write_req (io_write_req),
        .io_wdata     (io_wdata),
        .io_ready     (io_ready),
        .io_done      (io_done),
        .io_rdata     (io_rdata),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
`ifdef IO_OVERRUN_EN
        ,
        .rx_overrun   (rx_overrun),
        .rx_drop_cnt  (rx_drop_cnt)
`endif
    );

    int total = 0;
    int bad = 0;

    // reference model state
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    bit         rd_waiting = 0;
    bit         wr_waiting = 0;
    bit         done_seen = 0;
    bit         exp_tx_valid = 0;
    logic [7:0] exp_tx_data = 8'h00;
    logic [7:0] exp_rdata = 8'h00;
    logic [7:0] wr_byte = 8'h00;
    int         rx_rate = 0;
    int         tx_rate = 0;
    int         drops = 0;
    bit         overrun = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: choose random PHY activity, advance the model, compare outputs.
    task automatic tick();
        bit rx_pop, tx_push, tx_pop, rx_push, drop;
        tx_ready = ($urandom_range(0, 99) < tx_rate);
        if (!rx_valid && rx_rate > 0 && $urandom_range(0, 99) < rx_rate) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        rx_pop  = rd_waiting && rx_q.size() > 0;
        tx_push = wr_waiting && tx_q.size() < TXD;
        tx_pop  = exp_tx_valid && tx_ready;
        rx_push = rx_valid && (rx_q.size() < RXD || rx_pop);
        drop    = rx_valid && !rx_push;
        @(posedge CLK);
        #1;
        if (rx_pop) begin
            exp_rdata  = rx_q.pop_front();
            rd_waiting = 0;
        end
        if (rx_push) rx_q.push_back(rx_data);
        if (drop) begin
            overrun = 1;
            if (drops < 255) drops++;
        end
        if (tx_pop) void'(tx_q.pop_front());
        exp_tx_valid = tx_q.size() > 0;
        if (exp_tx_valid) exp_tx_data = tx_q[0];
        if (tx_push) begin
            tx_q.push_back(wr_byte);
            wr_waiting = 0;
        end
        done_seen = rx_pop || tx_push;
        chk("io_done", io_done, done_seen);
        if (rx_pop) chk("io_rdata", io_rdata, exp_rdata);
        chk("tx_valid", tx_valid, exp_tx_valid);
        if (exp_tx_valid) chk("tx_data", tx_data, exp_tx_data);
`ifdef IO_OVERRUN_EN
        chk("rx_overrun", rx_overrun, overrun);
        chk("rx_drop_cnt", rx_drop_cnt, drops);
`endif
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        io_read_req = 1'b0;
        io_write_req = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_io_ready", io_ready, 0);
        chk("rst_io_done", io_done, 0);
        chk("rst_io_rdata", io_rdata, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
`ifdef IO_OVERRUN_EN
        chk("rst_rx_overrun", rx_overrun, 0);
        chk("rst_rx_drop_cnt", rx_drop_cnt, 0);
`endif
        rx_q.delete();
        tx_q.delete();
        rd_waiting = 0;
        wr_waiting = 0;
        exp_tx_valid = 0;
        drops = 0;
        overrun = 0;
        RST = 1'b0;
        tick();
        chk("ready_after_rst", io_ready, 1);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
    endtask

    task automatic start_req(input bit rd, input bit wr, input logic [7:0] d);
        chk("ready_before_req", io_ready, 1);
        io_read_req  = rd;
        io_write_req = wr;
        io_wdata     = d;
        tick();
        if (rd) begin
            rd_waiting = 1;
        end else if (wr) begin
            wr_waiting = 1;
            wr_byte    = d;
        end
    endtask

    task automatic wait_done(input int budget, input string what);
        int n = 0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
        end
        chk({"done_in_budget_", what}, io_done, 1);
        $display("txn %s rdata=%02h wbyte=%02h wait=%0d", what, io_rdata, wr_byte, n);
    endtask

    task automatic release_req(input int hold);
        repeat (hold) begin
            tick();
            chk("ready_in_hold", io_ready, 0);
        end
        io_read_req  = 1'b0;
        io_write_req = 1'b0;
        tick();
        chk("ready_after_release", io_ready, 1);
    endtask

    initial begin
        tx_rate = 100;
        do_reset();

        // read with data already present
        push_rx(8'h41);
        start_req(1, 0, 8'h00);
        wait_done(20, "rd");
        chk("t1_rdata", io_rdata, 8'h41);
        release_req(3);

        // read waits on an empty RX FIFO
        start_req(1, 0, 8'h00);
        repeat (10) tick();
        push_rx(8'h7F);
        tick();
        chk("t2_done_plus2", io_done, 1);
        chk("t2_rdata", io_rdata, 8'h7F);
        release_req(1);

        // TX full back-pressure
        tx_rate = 0;
        for (int i = 0; i < TXD; i++) begin
            start_req(0, 1, 8'(i));
            wait_done(20, "wr");
            release_req(1);
        end
        start_req(0, 1, 8'h10);
        repeat (10) tick();
        chk("t3_stalled", io_done, 0);
        tx_rate = 100;
        wait_done(20, "wr");
        release_req(1);
        repeat (20) tick();
        chk("t3_drained", tx_valid, 0);

        // RX overflow drops the 17th byte
        for (int i = 0; i <= RXD; i++) push_rx(8'(8'h80 + i));
`ifdef IO_OVERRUN_EN
        chk("t4_overrun", rx_overrun, 1);
        chk("t4_drop_cnt", rx_drop_cnt, 1);
`endif
        for (int i = 0; i < RXD; i++) begin
            start_req(1, 0, 8'h00);
            wait_done(20, "rd");
            chk("t4_rdata", io_rdata, 8'h80 + i);
            release_req(1);
        end

        // simultaneous requests: read wins, write needs a fresh request
        push_rx(8'h55);
        start_req(1, 1, 8'hAA);
        wait_done(20, "rd");
        chk("t5_rdata", io_rdata, 8'h55);
        release_req(3);
        start_req(0, 1, 8'hAA);
        wait_done(20, "wr");
        release_req(1);
        repeat (4) tick();

        // reset while waiting in RD_WAIT
        tx_rate = 0;
        start_req(0, 1, 8'h21);
        wait_done(20, "wr");
        release_req(1);
        start_req(1, 0, 8'h00);
        repeat (3) tick();
        do_reset();
        chk("t6_tx_flushed", tx_valid, 0);
        push_rx(8'h11);
        push_rx(8'h22);
        do_reset();
        push_rx(8'h33);
        start_req(1, 0, 8'h00);
        wait_done(20, "rd");
        chk("t6_rx_flushed", io_rdata, 8'h33);
        release_req(1);

        // randomized traffic
        rx_rate = 20;
        tx_rate = 50;
        for (int k = 0; k < 120; k++) begin
            bit rd;
            rd = ($urandom_range(0, 1) == 1);
            start_req(rd, !rd, 8'($urandom));
            wait_done(300, rd ? "rnd_rd" : "rnd_wr");
            release_req(1 + $urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
